// File: rtl/awb_pkg.sv
// Shared types and constants for the AWB gain computation and pixel gain path.
// Gains are Q8.8; pixels are 8-bit unsigned.
package awb_pkg;

  localparam int PIX_W  = 8;
  localparam int GAIN_W = 16;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h0100;
  localparam logic [15:0]       DIV3_MUL   = 16'h5556;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_DIV,
    ST_MUL_R,
    ST_MUL_G,
    ST_MUL_B,
    ST_DONE
  } gain_state_t;

  // Input is the product already shifted down by 8; clamp to the pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [15:0] i_o);
    if (i_o > 16'd255) begin
      return 8'hFF;
    end
    return i_o[7:0];
  endfunction

endpackage

// File: rtl/awb_gain_apply_recip.sv
// Reciprocal ROM: floor(65536/n) in 16 bits, with recip(0)=0 and recip(1)=0xFFFF.
// Purely combinational; contents are fixed at elaboration.
module awb_gain_apply_recip (
  input  logic [7:0]  i_n,
  output logic [15:0] o_recip
);

  logic [15:0] w_rom [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    if (gi == 0) begin : g_zero
      assign w_rom[gi] = 16'h0000;
    end else if (gi == 1) begin : g_one
      assign w_rom[gi] = 16'hFFFF;
    end else begin : g_div
      assign w_rom[gi] = 16'(65536 / gi);
    end
  end

  assign o_recip = w_rom[i_n];

endmodule

// File: rtl/awb_gain_apply.sv
// Gray-world AWB gains via a sequential FSM (one shared reciprocal ROM), applied to
// RGB888 pixels in a 2-cycle saturating pipeline; gain sets swap only on a vsync rise.
module awb_gain_apply
  import awb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stat_valid,
  input  logic [PIX_W-1:0]  r_avg,
  input  logic [PIX_W-1:0]  g_avg,
  input  logic [PIX_W-1:0]  b_avg,
  output logic              gain_busy,
  output logic              gain_valid,
  output logic [GAIN_W-1:0] r_gain,
  output logic [GAIN_W-1:0] g_gain,
  output logic [GAIN_W-1:0] b_gain,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [PIX_W-1:0]  per_img_r,
  input  logic [PIX_W-1:0]  per_img_g,
  input  logic [PIX_W-1:0]  per_img_b,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [PIX_W-1:0]  post_img_r,
  output logic [PIX_W-1:0]  post_img_g,
  output logic [PIX_W-1:0]  post_img_b
);

  gain_state_t       r_state;
  logic [PIX_W-1:0]  r_lat_r, r_lat_g, r_lat_b;
  logic [9:0]        r_sum;
  logic [7:0]        r_k;
  logic [GAIN_W-1:0] r_calc_r, r_calc_g, r_calc_b;
  logic [GAIN_W-1:0] r_shd_r, r_shd_g, r_shd_b;
  logic [GAIN_W-1:0] r_act_r, r_act_g, r_act_b;
  logic              r_pending;
  logic              r_busy;
  logic              r_gain_valid;
  logic              r_vs_d;

  logic [PIX_W-1:0]  w_sel_avg;
  logic [15:0]       w_recip;
  logic [7:0]        w_k;
  logic [GAIN_W-1:0] w_gain;
  logic              w_vs_rise;

  // Multiply by 0x5556 and keep bits [23:16]: exact floor(sum/3) over 0..765.
  assign w_k = 8'((26'(r_sum) * 26'(DIV3_MUL)) >> 16);

  always_comb begin
    w_sel_avg = r_lat_b;
    case (r_state)
      ST_MUL_R: w_sel_avg = r_lat_r;
      ST_MUL_G: w_sel_avg = r_lat_g;
      default:  w_sel_avg = r_lat_b;
    endcase
  end

  awb_gain_apply_recip recip (
    .i_n     (w_sel_avg),
    .o_recip (w_recip)
  );

  // K <= 255 and recip <= 0xFFFF, so the Q8.8 result always fits in 16 bits.
  assign w_gain = (w_sel_avg == '0) ? GAIN_UNITY
                                    : 16'((24'(r_k) * 24'(w_recip)) >> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lat_r      <= '0;
      r_lat_g      <= '0;
      r_lat_b      <= '0;
      r_sum        <= '0;
      r_k          <= '0;
      r_calc_r     <= GAIN_UNITY;
      r_calc_g     <= GAIN_UNITY;
      r_calc_b     <= GAIN_UNITY;
      r_shd_r      <= GAIN_UNITY;
      r_shd_g      <= GAIN_UNITY;
      r_shd_b      <= GAIN_UNITY;
      r_busy       <= 1'b0;
      r_gain_valid <= 1'b0;
    end else begin
      r_gain_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (stat_valid) begin
            r_lat_r <= r_avg;
            r_lat_g <= g_avg;
            r_lat_b <= b_avg;
            r_busy  <= 1'b1;
            r_state <= ST_SUM;
          end
        end
        ST_SUM: begin
          r_sum   <= 10'(r_lat_r) + 10'(r_lat_g) + 10'(r_lat_b);
          r_state <= ST_DIV;
        end
        ST_DIV: begin
          r_k     <= w_k;
          r_state <= ST_MUL_R;
        end
        ST_MUL_R: begin
          r_calc_r <= w_gain;
          r_state  <= ST_MUL_G;
        end
        ST_MUL_G: begin
          r_calc_g <= w_gain;
          r_state  <= ST_MUL_B;
        end
        ST_MUL_B: begin
          r_calc_b     <= w_gain;
          r_gain_valid <= 1'b1;
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_shd_r <= r_calc_r;
          r_shd_g <= r_calc_g;
          r_shd_b <= r_calc_b;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_vs_rise = per_frame_vsync & ~r_vs_d;

  // A DONE coinciding with a vsync rise applies the previous shadow and keeps the new one pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_d    <= 1'b0;
      r_pending <= 1'b0;
      r_act_r   <= GAIN_UNITY;
      r_act_g   <= GAIN_UNITY;
      r_act_b   <= GAIN_UNITY;
    end else begin
      r_vs_d <= per_frame_vsync;
      if (w_vs_rise && r_pending) begin
        r_act_r <= r_shd_r;
        r_act_g <= r_shd_g;
        r_act_b <= r_shd_b;
      end
      if (r_state == ST_DONE) begin
        r_pending <= 1'b1;
      end else if (w_vs_rise) begin
        r_pending <= 1'b0;
      end
    end
  end

  logic [15:0] r_p_r, r_p_g, r_p_b;
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [PIX_W-1:0] r_out_r, r_out_g, r_out_b;

  // Stage 1 keeps only bits [23:8] of the 24-bit product; the low byte is never observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_r   <= '0;
      r_p_g   <= '0;
      r_p_b   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_out_r <= '0;
      r_out_g <= '0;
      r_out_b <= '0;
    end else begin
      r_p_r   <= 16'((24'(per_img_r) * 24'(r_act_r)) >> 8);
      r_p_g   <= 16'((24'(per_img_g) * 24'(r_act_g)) >> 8);
      r_p_b   <= 16'((24'(per_img_b) * 24'(r_act_b)) >> 8);
      r_sync1 <= {per_frame_vsync, per_frame_href, per_frame_clken};
      r_out_r <= sat_pix(r_p_r);
      r_out_g <= sat_pix(r_p_g);
      r_out_b <= sat_pix(r_p_b);
      r_sync2 <= r_sync1;
    end
  end

  assign gain_busy        = r_busy;
  assign gain_valid       = r_gain_valid;
  assign r_gain           = r_shd_r;
  assign g_gain           = r_shd_g;
  assign b_gain           = r_shd_b;
  assign post_frame_vsync = r_sync2[2];
  assign post_frame_href  = r_sync2[1];
  assign post_frame_clken = r_sync2[0];
  assign post_img_r       = r_out_r;
  assign post_img_g       = r_out_g;
  assign post_img_b       = r_out_b;

endmodule

// File: tb/tb_awb_gain_apply.sv
// Directed bench for awb_gain_apply: vector table for gain computation plus
// hand-written sequences for frame-boundary swaps, busy collision and mid-compute reset.
module tb_awb_gain_apply;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_valid;
  logic [7:0]  r_avg, g_avg, b_avg;
  logic        gain_busy, gain_valid;
  logic [15:0] r_gain, g_gain, b_gain;
  logic        per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0]  per_img_r, per_img_g, per_img_b;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]  post_img_r, post_img_g, post_img_b;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gain_valid === 1'b1) vld_cnt++;
  end

  awb_gain_apply dut (
    .clk              (clk),
    .rst              (rst),
    .stat_valid       (stat_valid),
    .r_avg            (r_avg),
    .g_avg            (g_avg),
    .b_avg            (b_avg),
    .gain_busy        (gain_busy),
    .gain_valid       (gain_valid),
    .r_gain           (r_gain),
    .g_gain           (g_gain),
    .b_gain           (b_gain),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_r        (per_img_r),
    .per_img_g        (per_img_g),
    .per_img_b        (per_img_b),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_r       (post_img_r),
    .post_img_g       (post_img_g),
    .post_img_b       (post_img_b)
  );

  typedef struct {
    logic [7:0]  r, g, b;
    logic [15:0] er, eg, eb;
  } vec_t;

  vec_t vecs[3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_gains(input string nm, input logic [15:0] er, input logic [15:0] eg,
                           input logic [15:0] eb);
    chk({nm, ".r_gain"}, 32'(r_gain), 32'(er));
    chk({nm, ".g_gain"}, 32'(g_gain), 32'(eg));
    chk({nm, ".b_gain"}, 32'(b_gain), 32'(eb));
  endtask

  // Pulse stat_valid, measure latency to gain_valid; optionally raise vsync in the DONE cycle.
  task automatic run_stat(input vec_t v, input bit vs_done, input string nm);
    int lat;
    int n0;
    n0 = vld_cnt;
    r_avg = v.r; g_avg = v.g; b_avg = v.b;
    stat_valid = 1'b1;
    step();
    stat_valid = 1'b0;
    chk({nm, ".busy_c1"}, 32'(gain_busy), 32'd1);
    lat = 1;
    while (gain_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd6);
    if (vs_done) per_frame_vsync = 1'b1;
    step();
    per_frame_vsync = 1'b0;
    chk({nm, ".valid_c7"}, 32'(gain_valid), 32'd0);
    chk({nm, ".busy_c7"}, 32'(gain_busy), 32'd0);
    chk({nm, ".pulses"}, 32'(vld_cnt - n0), 32'd1);
    chk_gains(nm, v.er, v.eg, v.eb);
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                     input string nm);
    per_img_r = r; per_img_g = g; per_img_b = b;
    per_frame_href = 1'b1; per_frame_clken = 1'b1;
    step();
    per_img_r = '0; per_img_g = '0; per_img_b = '0;
    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    chk({nm, ".href_c1"}, 32'(post_frame_href), 32'd0);
    step();
    chk({nm, ".pix_r"}, 32'(post_img_r), 32'(er));
    chk({nm, ".pix_g"}, 32'(post_img_g), 32'(eg));
    chk({nm, ".pix_b"}, 32'(post_img_b), 32'(eb));
    chk({nm, ".href_c2"}, 32'(post_frame_href), 32'd1);
    chk({nm, ".clken_c2"}, 32'(post_frame_clken), 32'd1);
    step();
  endtask

  task automatic vs_rise(input string nm);
    per_frame_vsync = 1'b1;
    step();
    chk({nm, ".vs_c1"}, 32'(post_frame_vsync), 32'd0);
    step();
    chk({nm, ".vs_c2"}, 32'(post_frame_vsync), 32'd1);
    per_frame_vsync = 1'b0;
    step();
  endtask

  initial begin
    int n0;
    int wait_cnt;

    vecs[0] = '{r: 8'd128, g: 8'd128, b: 8'd128, er: 16'h0100, eg: 16'h0100, eb: 16'h0100};
    vecs[1] = '{r: 8'd0,   g: 8'd100, b: 8'd100, er: 16'h0100, eg: 16'h00A8, eb: 16'h00A8};
    vecs[2] = '{r: 8'd64,  g: 8'd128, b: 8'd192, er: 16'h0200, eg: 16'h0100, eb: 16'h00AA};

    // Reset with live-looking inputs: outputs must still read zero.
    rst = 1'b1;
    stat_valid = 1'b0;
    r_avg = '0; g_avg = '0; b_avg = '0;
    per_frame_vsync = 1'b1; per_frame_href = 1'b1; per_frame_clken = 1'b1;
    per_img_r = 8'hFF; per_img_g = 8'hFF; per_img_b = 8'hFF;
    repeat (3) step();
    chk("rst.post_r", 32'(post_img_r), 32'd0);
    chk("rst.post_g", 32'(post_img_g), 32'd0);
    chk("rst.post_b", 32'(post_img_b), 32'd0);
    chk("rst.post_vs", 32'(post_frame_vsync), 32'd0);
    chk("rst.post_href", 32'(post_frame_href), 32'd0);
    chk("rst.post_clken", 32'(post_frame_clken), 32'd0);
    chk("rst.busy", 32'(gain_busy), 32'd0);
    chk("rst.valid", 32'(gain_valid), 32'd0);
    chk_gains("rst", 16'h0100, 16'h0100, 16'h0100);
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_r = '0; per_img_g = '0; per_img_b = '0;
    rst = 1'b0;
    step();
    step();

    // Gray, zero channel, cast: shadow ends as the cast set, active still unity.
    run_stat(vecs[0], 1'b0, "gray");
    run_stat(vecs[1], 1'b0, "zero");
    run_stat(vecs[2], 1'b0, "cast");

    pix(8'd200, 8'd100, 8'd200, 8'd200, 8'd100, 8'd200, "pre_vsync");
    vs_rise("vs1");
    pix(8'd200, 8'd100, 8'd200, 8'd255, 8'd100, 8'd132, "cast_pix");

    // Shadow=zero set, then gray computed with a vsync rise on its DONE cycle.
    run_stat(vecs[1], 1'b0, "zero2");
    run_stat(vecs[0], 1'b1, "done_vs");
    pix(8'd200, 8'd100, 8'd200, 8'd200, 8'd65, 8'd131, "old_shadow");
    vs_rise("vs2");
    pix(8'd200, 8'd100, 8'd200, 8'd200, 8'd100, 8'd200, "new_pending");

    // Busy collision: second stat_valid in cycle 3 is ignored.
    n0 = vld_cnt;
    r_avg = 8'd64; g_avg = 8'd128; b_avg = 8'd192;
    stat_valid = 1'b1;
    step();
    stat_valid = 1'b0;
    step();
    step();
    r_avg = 8'd0; g_avg = 8'd100; b_avg = 8'd100;
    stat_valid = 1'b1;
    step();
    stat_valid = 1'b0;
    wait_cnt = 0;
    while (gain_busy === 1'b1 && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    chk("coll.busy_done", 32'(gain_busy), 32'd0);
    repeat (3) step();
    chk("coll.pulses", 32'(vld_cnt - n0), 32'd1);
    chk_gains("coll", 16'h0200, 16'h0100, 16'h00AA);

    // Reset asserted in cycle 4 of a computation.
    n0 = vld_cnt;
    r_avg = 8'd0; g_avg = 8'd100; b_avg = 8'd100;
    stat_valid = 1'b1;
    step();
    stat_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.busy", 32'(gain_busy), 32'd0);
    chk_gains("mrst", 16'h0100, 16'h0100, 16'h0100);
    repeat (8) step();
    chk("mrst.pulses", 32'(vld_cnt - n0), 32'd0);
    chk_gains("mrst_late", 16'h0100, 16'h0100, 16'h0100);
    pix(8'd200, 8'd100, 8'd200, 8'd200, 8'd100, 8'd200, "mrst_active");
    run_stat(vecs[2], 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
